ps2_kbd_ctrl: RTL and testbench

PS2_KBD_CTRL -- requirements
Module: ps2_kbd_ctrl

---
 rtl/ps2_pkg.sv | 31 +++
 rtl/ps2_cmd_timer.sv | 40 ++++
 rtl/ps2_kbd_ctrl.sv | 274 +++++++++++++++++++++++++++
 tb/tb_ps2_kbd_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 keyboard command controller:
// keyboard host status codes, keyboard command codes, FSM and source encodings.
package ps2_pkg;

    // Keyboard host status codes seen on stat_i
    localparam logic [7:0] ST_IDLE   = 8'h00;
    localparam logic [7:0] ST_PEND   = 8'h01;
    localparam logic [7:0] ST_ACK    = 8'hFA;
    localparam logic [7:0] ST_ERR    = 8'hFE;
    localparam logic [7:0] ST_BAT_OK = 8'hAA;

    // Keyboard command codes
    localparam logic [7:0] CMD_SET_LED   = 8'hED;
    localparam logic [7:0] CMD_TYPEMATIC = 8'hF3;
    localparam logic [7:0] CMD_ENABLE    = 8'hF4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE_CMD,
        S_ISSUE_DATA,
        S_WAIT_REPLY
    } ps2_state_e;

    // Which kind of work the in-flight transaction belongs to
    typedef enum logic [1:0] {
        SRC_INIT,
        SRC_LED,
        SRC_CPU
    } ps2_src_e;

endpackage

// File: rtl/ps2_cmd_timer.sv
// Reply timeout counter for ps2_kbd_ctrl; only instantiated when
// PS2_KBD_CTRL_TIMEOUT_EN is defined. Counts ck1us pulses while run is high,
// holds at TIMEOUT_US and is cleared whenever run is low.
module ps2_cmd_timer #(
    parameter int unsigned TIMEOUT_US = 20000
) (
    input  logic clk6x,
    input  logic reset,
    input  logic run,
    input  logic ck1us,
    output logic expired_o
);

    localparam int unsigned W = (TIMEOUT_US < 2) ? 1 : $clog2(TIMEOUT_US + 1);
    localparam logic [W-1:0] LIMIT = W'(TIMEOUT_US);

    logic [W-1:0] cnt_q, cnt_d;

    // Next count: clear outside the wait, saturate at the limit
    always_comb begin
        cnt_d = cnt_q;
        if (!run) begin
            cnt_d = '0;
        end else if (ck1us && (cnt_q != LIMIT)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register
    always_ff @(posedge clk6x) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = run && (cnt_q == LIMIT);

endmodule

// File: rtl/ps2_kbd_ctrl.sv
// PS/2 keyboard command controller: runs the post-BAT init sequence
// (ED+LEDs, F3+typematic, F4), forwards LED changes and a single queued CPU
// command, with ACK/ERR handling and bounded retries.
// Optional reply timeout: define PS2_KBD_CTRL_TIMEOUT_EN.
module ps2_kbd_ctrl
    import ps2_pkg::*;
#(
    parameter logic [7:0]  TYPEMATIC  = 8'h20,
    parameter int unsigned MAX_RETRY  = 2,
    parameter int unsigned TIMEOUT_US = 20000
) (
    input  logic       clk6x,
    input  logic       reset,
    input  logic       ck1us,
    input  logic       bat_ok_i,
    input  logic [7:0] stat_i,
    input  logic [2:0] led_i,
    input  logic       cpu_req_i,
    input  logic [7:0] cpu_cmd_i,
    input  logic [7:0] cpu_data_i,
    input  logic       cpu_two_i,
    output logic [7:0] wcmddata_o,
    output logic       enq_cmd1_o,
    output logic       enq_cmd2_o,
    output logic       busy_o,
    output logic       cpu_done_o,
    output logic       cpu_err_o,
    output logic       cpu_drop_o,
    output logic       init_done_o,
    output logic       init_fail_o
);

    localparam int unsigned RW = (MAX_RETRY < 2) ? 1 : $clog2(MAX_RETRY + 1);

    ps2_state_e  state_q, state_d;
    ps2_src_e    src_q, src_d;
    logic [7:0]  cmd_q, cmd_d;
    logic [7:0]  data_q, data_d;
    logic        two_q, two_d;
    logic        ledsrc_q, ledsrc_d;
    logic [RW-1:0] retry_q, retry_d;
    logic        pend_seen_q, pend_seen_d;
    logic        restart_q, restart_d;
    logic        init_pend_q, init_pend_d;
    logic [1:0]  init_step_q, init_step_d;
    logic        init_done_q, init_done_d;
    logic        init_fail_q, init_fail_d;
    logic [2:0]  led_last_q, led_last_d;
    logic        slot_full_q, slot_full_d;
    logic [7:0]  slot_cmd_q, slot_cmd_d;
    logic [7:0]  slot_data_q, slot_data_d;
    logic        slot_two_q, slot_two_d;

    logic led_pend;
    logic in_wait;
    logic timeout_hit;
    logic rx_ack;
    logic rx_err;
    logic retry_ok;
    logic final_fail;

`ifdef PS2_KBD_CTRL_TIMEOUT_EN
    ps2_cmd_timer #(
        .TIMEOUT_US (TIMEOUT_US)
    ) u_timer (
        .clk6x     (clk6x),
        .reset     (reset),
        .run       (in_wait),
        .ck1us     (ck1us),
        .expired_o (timeout_hit)
    );
`else
    logic unused_cfg;
    assign unused_cfg  = ck1us ^ (TIMEOUT_US == 32'd0);
    assign timeout_hit = 1'b0;
`endif

    assign in_wait    = (state_q == S_WAIT_REPLY);
    assign led_pend   = init_done_q && (led_i != led_last_q);
    assign rx_ack     = in_wait && pend_seen_q && (stat_i == ST_ACK);
    assign rx_err     = in_wait && ((pend_seen_q && (stat_i == ST_ERR)) || timeout_hit);
    assign retry_ok   = (32'(retry_q) < MAX_RETRY);
    assign final_fail = rx_err && !retry_ok;

    // Next-state: work selection, issue sequencing, reply handling, slot and init flags.
    // A BAT OK arriving while a transaction is selected or in flight marks it
    // stale (restart) so its completion does not advance the restarted init.
    always_comb begin
        state_d     = state_q;
        src_d       = src_q;
        cmd_d       = cmd_q;
        data_d      = data_q;
        two_d       = two_q;
        ledsrc_d    = ledsrc_q;
        retry_d     = retry_q;
        pend_seen_d = pend_seen_q;
        restart_d   = restart_q;
        init_pend_d = init_pend_q;
        init_step_d = init_step_q;
        init_done_d = init_done_q;
        init_fail_d = init_fail_q;
        led_last_d  = led_last_q;
        slot_full_d = slot_full_q;
        slot_cmd_d  = slot_cmd_q;
        slot_data_d = slot_data_q;
        slot_two_d  = slot_two_q;

        unique case (state_q)
            S_IDLE: begin
                retry_d   = '0;
                restart_d = 1'b0;
                if (init_pend_q) begin
                    state_d = S_ISSUE_CMD;
                    src_d   = SRC_INIT;
                    case (init_step_q)
                        2'd0: begin
                            cmd_d    = CMD_SET_LED;
                            two_d    = 1'b1;
                            ledsrc_d = 1'b1;
                        end
                        2'd1: begin
                            cmd_d    = CMD_TYPEMATIC;
                            data_d   = TYPEMATIC;
                            two_d    = 1'b1;
                            ledsrc_d = 1'b0;
                        end
                        default: begin
                            cmd_d    = CMD_ENABLE;
                            data_d   = '0;
                            two_d    = 1'b0;
                            ledsrc_d = 1'b0;
                        end
                    endcase
                end else if (led_pend) begin
                    state_d  = S_ISSUE_CMD;
                    src_d    = SRC_LED;
                    cmd_d    = CMD_SET_LED;
                    two_d    = 1'b1;
                    ledsrc_d = 1'b1;
                end else if (slot_full_q) begin
                    state_d     = S_ISSUE_CMD;
                    src_d       = SRC_CPU;
                    cmd_d       = slot_cmd_q;
                    data_d      = slot_data_q;
                    two_d       = slot_two_q;
                    ledsrc_d    = 1'b0;
                    slot_full_d = 1'b0;
                end
            end
            S_ISSUE_CMD: begin
                pend_seen_d = 1'b0;
                // LED data is sampled on the first attempt only; retries resend the same byte
                if (ledsrc_q && (retry_q == '0)) begin
                    data_d     = {5'b0, led_i};
                    led_last_d = led_i;
                end
                state_d = two_q ? S_ISSUE_DATA : S_WAIT_REPLY;
            end
            S_ISSUE_DATA: begin
                pend_seen_d = 1'b0;
                state_d     = S_WAIT_REPLY;
            end
            S_WAIT_REPLY: begin
                if (stat_i == ST_PEND) begin
                    pend_seen_d = 1'b1;
                end
                if (rx_ack || final_fail) begin
                    state_d = S_IDLE;
                    if ((src_q == SRC_INIT) && !restart_q) begin
                        if (rx_ack) begin
                            if (init_step_q == 2'd2) begin
                                init_pend_d = 1'b0;
                                init_step_d = 2'd0;
                                init_done_d = 1'b1;
                            end else begin
                                init_step_d = init_step_q + 2'd1;
                            end
                        end else begin
                            init_pend_d = 1'b0;
                            init_step_d = 2'd0;
                            init_fail_d = 1'b1;
                        end
                    end
                end else if (rx_err) begin
                    retry_d = retry_q + 1'b1;
                    state_d = S_ISSUE_CMD;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (cpu_req_i && !slot_full_q) begin
            slot_full_d = 1'b1;
            slot_cmd_d  = cpu_cmd_i;
            slot_data_d = cpu_data_i;
            slot_two_d  = cpu_two_i;
        end

        if (bat_ok_i) begin
            init_pend_d = 1'b1;
            init_step_d = 2'd0;
            init_done_d = 1'b0;
            init_fail_d = 1'b0;
            restart_d   = (state_d != S_IDLE);
        end
    end

    // Outputs: enqueue strobes and byte during issue cycles, completion pulses
    always_comb begin
        wcmddata_o = '0;
        enq_cmd1_o = 1'b0;
        enq_cmd2_o = 1'b0;
        if (!reset) begin
            if (state_q == S_ISSUE_CMD) begin
                wcmddata_o = cmd_q;
                enq_cmd2_o = two_q;
                enq_cmd1_o = !two_q;
            end else if (state_q == S_ISSUE_DATA) begin
                wcmddata_o = data_q;
                enq_cmd1_o = 1'b1;
            end
        end
        cpu_done_o  = !reset && rx_ack && (src_q == SRC_CPU);
        cpu_err_o   = !reset && final_fail && (src_q == SRC_CPU);
        cpu_drop_o  = !reset && cpu_req_i && slot_full_q;
        busy_o      = !reset && ((state_q != S_IDLE) || init_pend_q || led_pend || slot_full_q);
        init_done_o = init_done_q;
        init_fail_o = init_fail_q;
    end

    // State and flag registers
    always_ff @(posedge clk6x) begin
        if (reset) begin
            state_q     <= S_IDLE;
            src_q       <= SRC_INIT;
            cmd_q       <= '0;
            data_q      <= '0;
            two_q       <= 1'b0;
            ledsrc_q    <= 1'b0;
            retry_q     <= '0;
            pend_seen_q <= 1'b0;
            restart_q   <= 1'b0;
            init_pend_q <= 1'b0;
            init_step_q <= 2'd0;
            init_done_q <= 1'b0;
            init_fail_q <= 1'b0;
            led_last_q  <= 3'b000;
            slot_full_q <= 1'b0;
            slot_cmd_q  <= '0;
            slot_data_q <= '0;
            slot_two_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            src_q       <= src_d;
            cmd_q       <= cmd_d;
            data_q      <= data_d;
            two_q       <= two_d;
            ledsrc_q    <= ledsrc_d;
            retry_q     <= retry_d;
            pend_seen_q <= pend_seen_d;
            restart_q   <= restart_d;
            init_pend_q <= init_pend_d;
            init_step_q <= init_step_d;
            init_done_q <= init_done_d;
            init_fail_q <= init_fail_d;
            led_last_q  <= led_last_d;
            slot_full_q <= slot_full_d;
            slot_cmd_q  <= slot_cmd_d;
            slot_data_q <= slot_data_d;
            slot_two_q  <= slot_two_d;
        end
    end

endmodule

// File: tb/tb_ps2_kbd_ctrl.sv
// Directed bench for ps2_kbd_ctrl: init sequence, retries, LED updates,
// CPU slot arbitration, reset abort and (with PS2_KBD_CTRL_TIMEOUT_EN) timeouts.
module tb_ps2_kbd_ctrl;
    import ps2_pkg::*;

`ifdef PS2_KBD_CTRL_TIMEOUT_EN
    localparam int unsigned TB_TIMEOUT = 50;
`else
    localparam int unsigned TB_TIMEOUT = 20000;
`endif

    logic       clk6x = 1'b0;
    logic       reset = 1'b1;
    logic       ck1us = 1'b0;
    logic       bat_ok_i = 1'b0;
    logic [7:0] stat_i = 8'h00;
    logic [2:0] led_i = 3'b000;
    logic       cpu_req_i = 1'b0;
    logic [7:0] cpu_cmd_i = 8'h00;
    logic [7:0] cpu_data_i = 8'h00;
    logic       cpu_two_i = 1'b0;
    logic [7:0] wcmddata_o;
    logic       enq_cmd1_o, enq_cmd2_o, busy_o;
    logic       cpu_done_o, cpu_err_o, cpu_drop_o;
    logic       init_done_o, init_fail_o;

    ps2_kbd_ctrl #(
        .TYPEMATIC  (8'h20),
        .MAX_RETRY  (2),
        .TIMEOUT_US (TB_TIMEOUT)
    ) dut (
        .clk6x       (clk6x),
        .reset       (reset),
        .ck1us       (ck1us),
        .bat_ok_i    (bat_ok_i),
        .stat_i      (stat_i),
        .led_i       (led_i),
        .cpu_req_i   (cpu_req_i),
        .cpu_cmd_i   (cpu_cmd_i),
        .cpu_data_i  (cpu_data_i),
        .cpu_two_i   (cpu_two_i),
        .wcmddata_o  (wcmddata_o),
        .enq_cmd1_o  (enq_cmd1_o),
        .enq_cmd2_o  (enq_cmd2_o),
        .busy_o      (busy_o),
        .cpu_done_o  (cpu_done_o),
        .cpu_err_o   (cpu_err_o),
        .cpu_drop_o  (cpu_drop_o),
        .init_done_o (init_done_o),
        .init_fail_o (init_fail_o)
    );

    always #5 clk6x = ~clk6x;

    // 1 us tick: one pulse every 4 clocks
    initial begin
        forever begin
            repeat (3) @(posedge clk6x);
            #1 ck1us = 1'b1;
            @(posedge clk6x);
            #1 ck1us = 1'b0;
        end
    end

    int unsigned n_vec = 0;
    int unsigned n_bad = 0;
    logic [9:0]  enq_log[$];
    int unsigned us_at_issue[$];
    int unsigned us_cnt = 0;
    int unsigned n_done = 0, n_err = 0, n_drop = 0;

    // Monitor: log {enq2, enq1, byte} and count pulses
    always @(negedge clk6x) begin
        if (enq_cmd1_o || enq_cmd2_o) enq_log.push_back({enq_cmd2_o, enq_cmd1_o, wcmddata_o});
        if (enq_cmd1_o) us_at_issue.push_back(us_cnt);
        if (ck1us) us_cnt++;
        if (cpu_done_o) n_done++;
        if (cpu_err_o) n_err++;
        if (cpu_drop_o) n_drop++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk6x);
        #1;
    endtask

    function automatic int unsigned n_entries(input logic [9:0] e);
        int unsigned c = 0;
        foreach (enq_log[i]) if (enq_log[i] == e) c++;
        return c;
    endfunction

    function automatic logic [9:0] log_at(input int unsigned i);
        if (i < enq_log.size()) return enq_log[i];
        return 10'h3FF;
    endfunction

    task automatic wait_issue(input string tag);
        bit seen = 0;
        for (int i = 0; i < 600 && !seen; i++) begin
            @(negedge clk6x);
            if (enq_cmd1_o) seen = 1;
        end
        if (!seen) check({tag, "_no_issue"}, 32'd0, 32'd1);
    endtask

    task automatic kbd_reply(input logic [7:0] code);
        @(posedge clk6x); #1 stat_i = ST_PEND;
        @(posedge clk6x); #1 stat_i = code;
        @(posedge clk6x); #1 stat_i = ST_IDLE;
    endtask

    task automatic kbd(input string tag, input logic [7:0] code);
        wait_issue(tag);
        kbd_reply(code);
    endtask

    task automatic pulse_bat();
        @(posedge clk6x); #1 bat_ok_i = 1'b1;
        @(posedge clk6x); #1 bat_ok_i = 1'b0;
    endtask

    task automatic cpu_req(input logic [7:0] cmd, input logic [7:0] data, input logic two);
        @(posedge clk6x); #1;
        cpu_req_i = 1'b1; cpu_cmd_i = cmd; cpu_data_i = data; cpu_two_i = two;
        @(posedge clk6x); #1;
        cpu_req_i = 1'b0;
    endtask

    function automatic logic [15:0] out_vec();
        return {wcmddata_o, enq_cmd2_o, enq_cmd1_o, busy_o, cpu_done_o,
                cpu_err_o, cpu_drop_o, init_done_o, init_fail_o};
    endfunction

    logic [9:0] exp_a [5];
    int unsigned d0, e0, p0;

    initial begin
        exp_a = '{10'h2ED, 10'h102, 10'h2F3, 10'h120, 10'h1F4};

        // Reset state
        tick(3);
        @(negedge clk6x);
        check("rst_outs_in_reset", 32'(out_vec()), 32'd0);
        @(posedge clk6x); #1 reset = 1'b0;
        tick(2);
        check("rst_outs_after", 32'(out_vec()), 32'd0);

        // Init sequence with ACKs, led=010
        led_i = 3'b010;
        enq_log.delete();
        pulse_bat();
        kbd("a0", ST_ACK);
        kbd("a1", ST_ACK);
        kbd("a2", ST_ACK);
        tick(3);
        check("a_len", enq_log.size(), 5);
        for (int i = 0; i < 5; i++) check($sformatf("a_byte%0d", i), 32'(log_at(i)), 32'(exp_a[i]));
        check("a_done_fail_busy", {init_done_o, init_fail_o, busy_o}, 3'b100);

        // LED update: unchanged -> nothing; 000 then 100
        enq_log.delete();
        tick(20);
        check("led_same_none", enq_log.size(), 0);
        led_i = 3'b000;
        kbd("l0", ST_ACK);
        tick(3);
        enq_log.delete();
        led_i = 3'b100;
        kbd("l1", ST_ACK);
        tick(30);
        check("led_len", enq_log.size(), 2);
        check("led_cmd", 32'(log_at(0)), 32'h2ED);
        check("led_data", 32'(log_at(1)), 32'h104);
        check("led_busy", busy_o, 1'b0);

        // ERR retry on step 1: FE, FE, FA
        enq_log.delete();
        pulse_bat();
        check("c_done_cleared", init_done_o, 1'b0);
        kbd("c0", ST_ACK);
        kbd("c1a", ST_ERR);
        kbd("c1b", ST_ERR);
        kbd("c1c", ST_ACK);
        kbd("c2", ST_ACK);
        tick(3);
        check("c_f3_count", n_entries(10'h2F3), 3);
        check("c_f3_data_count", n_entries(10'h120), 3);
        check("c_f4_count", n_entries(10'h1F4), 1);
        check("c_done_fail", {init_done_o, init_fail_o}, 2'b10);

        // Retry exhaustion on step 0
        enq_log.delete();
        pulse_bat();
        kbd("d0a", ST_ERR);
        kbd("d0b", ST_ERR);
        kbd("d0c", ST_ERR);
        tick(40);
        check("d_len", enq_log.size(), 6);
        check("d_no_f3", n_entries(10'h2F3), 0);
        check("d_done_fail_busy", {init_done_o, init_fail_o, busy_o}, 3'b010);

        // CPU arbitration during step 0 reply wait
        enq_log.delete();
        d0 = n_done; e0 = n_err; p0 = n_drop;
        pulse_bat();
        wait_issue("e0");
        cpu_req(8'hEE, 8'h00, 1'b0);
        cpu_req(8'hF0, 8'h02, 1'b1);
        tick(1);
        check("e_drop", n_drop - p0, 1);
        check("e_busy", busy_o, 1'b1);
        kbd_reply(ST_ACK);
        kbd("e1", ST_ACK);
        kbd("e2", ST_ACK);
        check("e_not_before_init", n_entries(10'h1EE), 0);
        kbd("e3", ST_ACK);
        tick(3);
        check("e_cpu_issued", n_entries(10'h1EE), 1);
        check("e_dropped_never", n_entries(10'h2F0), 0);
        check("e_done", n_done - d0, 1);
        check("e_err", n_err - e0, 0);
        check("e_init_done", init_done_o, 1'b1);

        // CPU 2-byte command
        enq_log.delete();
        d0 = n_done;
        cpu_req(8'hF0, 8'h02, 1'b1);
        kbd("f", ST_ACK);
        tick(3);
        check("f_len", enq_log.size(), 2);
        check("f_cmd", 32'(log_at(0)), 32'h2F0);
        check("f_data", 32'(log_at(1)), 32'h102);
        check("f_done", n_done - d0, 1);

        // ERR before pending is ignored
        enq_log.delete();
        d0 = n_done; e0 = n_err;
        cpu_req(8'hEE, 8'h00, 1'b0);
        wait_issue("g");
        @(posedge clk6x); #1 stat_i = ST_ERR;
        @(posedge clk6x); #1 stat_i = ST_PEND;
        @(posedge clk6x); #1 stat_i = ST_ACK;
        @(posedge clk6x); #1 stat_i = ST_IDLE;
        tick(10);
        check("g_len", enq_log.size(), 1);
        check("g_done_err", {n_done - d0, n_err - e0}, {32'd1, 32'd0});

        // CPU final failure
        enq_log.delete();
        d0 = n_done; e0 = n_err;
        cpu_req(8'hEE, 8'h00, 1'b0);
        kbd("h0", ST_ERR);
        kbd("h1", ST_ERR);
        kbd("h2", ST_ERR);
        tick(10);
        check("h_issues", enq_log.size(), 3);
        check("h_done_err", {n_done - d0, n_err - e0}, {32'd0, 32'd1});

        // Reset mid-transaction: no completion pulse
        d0 = n_done; e0 = n_err;
        cpu_req(8'hEE, 8'h00, 1'b0);
        wait_issue("i");
        @(posedge clk6x); #1 stat_i = ST_PEND;
        @(posedge clk6x); #1 stat_i = ST_ACK; reset = 1'b1;
        @(posedge clk6x); #1 stat_i = ST_IDLE;
        tick(2);
        reset = 1'b0;
        tick(3);
        check("i_no_pulse", {n_done - d0, n_err - e0}, {32'd0, 32'd0});
        check("i_outs", 32'(out_vec()), 32'd0);

`ifdef PS2_KBD_CTRL_TIMEOUT_EN
        // Timeout: stat held at pending, three attempts then cpu_err
        enq_log.delete();
        us_at_issue.delete();
        e0 = n_err;
        cpu_req(8'hEE, 8'h00, 1'b0);
        @(posedge clk6x); #1 stat_i = ST_PEND;
        wait_issue("j0");
        wait_issue("j1");
        wait_issue("j2");
        for (int i = 0; i < 400 && (n_err == e0); i++) tick(1);
        stat_i = ST_IDLE;
        tick(3);
        check("j_issues", enq_log.size(), 3);
        check("j_err", n_err - e0, 1);
        check("j_gap", (us_at_issue.size() >= 2) &&
              (us_at_issue[1] - us_at_issue[0] >= 50) &&
              (us_at_issue[1] - us_at_issue[0] <= 51), 1'b1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
